// File: rtl/vga_fb_scheduler.sv
// ---------------------------------------------------------------------------------------------
// vga_fb_scheduler
//
// Shares one single-port framebuffer RAM between VGA scanout and CPU pixel writes. Scanout
// pixels are prefetched in raster order into a small FIFO and handed to the VGA timing block
// one per pop. CPU writes take whatever RAM slots scanout does not need. When the FIFO runs
// low, scanout reads take priority over the CPU.
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active-low
//   i_frame_start  1-cycle pulse before the first active pixel; flushes FIFO, restarts fetch
//   i_pix_pop      VGA consumes one pixel this cycle
//   o_pix_data     registered pixel {r,g,b}, valid the cycle after i_pix_pop
//   o_underflow    sticky per frame: a pop found the FIFO empty
//   i_cpu_req      CPU write request, addr/data held stable until o_cpu_gnt
//   i_cpu_addr     linear pixel address (y*H_RES+x)
//   i_cpu_wdata    pixel to write
//   o_cpu_gnt      1-cycle pulse: CPU write issued to RAM this cycle
//   o_mem_en       RAM access strobe
//   o_mem_we       RAM write enable (0 = read)
//   o_mem_addr     RAM address
//   o_mem_wdata    RAM write data
//   i_mem_rdata    RAM read data, valid exactly one cycle after a read access
// ---------------------------------------------------------------------------------------------
module vga_fb_scheduler #(
  parameter int unsigned H_RES         = 640,
  parameter int unsigned V_RES         = 480,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned LOW_WATER     = 3,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_start,
  input  logic        i_pix_pop,
  output logic [23:0] o_pix_data,
  output logic        o_underflow,
  input  logic        i_cpu_req,
  input  logic [18:0] i_cpu_addr,
  input  logic [23:0] i_cpu_wdata,
  output logic        o_cpu_gnt,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [18:0] o_mem_addr,
  output logic [23:0] o_mem_wdata,
  input  logic [23:0] i_mem_rdata
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [18:0]     LastAddr = 19'(H_RES * V_RES - 1);
  localparam logic [CntW-1:0] LowLvl   = CntW'(LOW_WATER);
  localparam logic [CntW-1:0] FullLvl  = CntW'(FIFO_DEPTH);

  // State
  logic [23:0]     r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_occ;
  logic            r_inflt;
  logic [18:0]     r_fetch_ptr;
  logic            r_fetch_active;
  logic [23:0]     r_pix_data;
  logic            r_underflow;

  // Next-state and decode
  logic [PtrW-1:0] w_wr_ptr_nxt;
  logic [PtrW-1:0] w_rd_ptr_nxt;
  logic [CntW-1:0] w_occ_nxt;
  logic [18:0]     w_fetch_ptr_nxt;
  logic            w_fetch_active_nxt;
  logic [23:0]     w_pix_data_nxt;
  logic            w_underflow_nxt;

  logic [CntW-1:0] w_resv;
  logic            w_urgent;
  logic            w_room;
  logic            w_rd;
  logic            w_wr;
  logic            w_push;
  logic            w_pop_ok;
  logic            w_pop_empty;

  // Reserved FIFO slots: stored entries plus the read whose data is still on its way.
  assign w_resv   = r_occ + {{PtrW{1'b0}}, r_inflt};
  assign w_urgent = r_fetch_active && (w_resv < LowLvl);
  assign w_room   = r_fetch_active && (w_resv < FullLvl);

  // One RAM access per cycle. The scanout never reads in the frame_start cycle, so a flush
  // cannot race with a new read. The arbiter is held off while rst is asserted so that the
  // combinational RAM strobes and grant read as zero during reset too.
  always_comb begin
    w_rd = 1'b0;
    w_wr = 1'b0;
    if (rst) begin
      if (!i_frame_start && w_urgent) begin
        w_rd = 1'b1;
      end else if (i_cpu_req) begin
        w_wr = 1'b1;
      end else if (!i_frame_start && w_room) begin
        w_rd = 1'b1;
      end
    end
  end

  always_comb begin
    o_mem_en    = w_rd | w_wr;
    o_mem_we    = w_wr;
    o_cpu_gnt   = w_wr;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_wr) begin
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
    end else if (w_rd) begin
      o_mem_addr  = r_fetch_ptr;
    end
  end

  // A return that lands together with frame_start belongs to the old frame and is dropped.
  assign w_push      = r_inflt && !i_frame_start;
  // Occupancy is the pre-push value, so a word pushed this cycle is not yet poppable.
  assign w_pop_ok    = i_pix_pop && !i_frame_start && (r_occ != '0);
  assign w_pop_empty = i_pix_pop && !i_frame_start && (r_occ == '0);

  always_comb begin
    w_wr_ptr_nxt       = r_wr_ptr;
    w_rd_ptr_nxt       = r_rd_ptr;
    w_occ_nxt          = r_occ;
    w_fetch_ptr_nxt    = r_fetch_ptr;
    w_fetch_active_nxt = r_fetch_active;
    w_pix_data_nxt     = r_pix_data;
    w_underflow_nxt    = r_underflow;

    if (i_frame_start) begin
      w_wr_ptr_nxt       = '0;
      w_rd_ptr_nxt       = '0;
      w_occ_nxt          = '0;
      w_fetch_ptr_nxt    = '0;
      w_fetch_active_nxt = 1'b1;
      w_underflow_nxt    = 1'b0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + PtrW'(1);
      end
      if (w_pop_ok) begin
        w_rd_ptr_nxt   = r_rd_ptr + PtrW'(1);
        w_pix_data_nxt = r_fifo[r_rd_ptr];
      end
      if (w_pop_empty) begin
        w_pix_data_nxt  = UNDERFLOW_RGB;
        w_underflow_nxt = 1'b1;
      end

      case ({w_push, w_pop_ok})
        2'b10:   w_occ_nxt = r_occ + CntW'(1);
        2'b01:   w_occ_nxt = r_occ - CntW'(1);
        default: w_occ_nxt = r_occ;
      endcase

      // The pointer parks on the last pixel; fetch_active drops once that address is issued.
      if (w_rd) begin
        if (r_fetch_ptr == LastAddr) begin
          w_fetch_active_nxt = 1'b0;
        end else begin
          w_fetch_ptr_nxt = r_fetch_ptr + 19'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_occ          <= '0;
      r_inflt        <= 1'b0;
      r_fetch_ptr    <= '0;
      r_fetch_active <= 1'b0;
      r_pix_data     <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_occ          <= w_occ_nxt;
      r_inflt        <= w_rd;
      r_fetch_ptr    <= w_fetch_ptr_nxt;
      r_fetch_active <= w_fetch_active_nxt;
      r_pix_data     <= w_pix_data_nxt;
      r_underflow    <= w_underflow_nxt;
    end
  end

  // FIFO storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= i_mem_rdata;
    end
  end

  assign o_pix_data  = r_pix_data;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// ---------------------------------------------------------------------------------------------
// tb_vga_fb_scheduler
//
// Bench for vga_fb_scheduler on a reduced 16x4 frame. A behavioural RAM holds RAM[a]=a.
// Expected pixels and expected CPU writes are queued when stimulus is driven and compared
// when the DUT produces them; scanout read addresses are tracked against a raster counter.
// ---------------------------------------------------------------------------------------------
module tb_vga_fb_scheduler;

  localparam int unsigned HRes = 16;
  localparam int unsigned VRes = 4;
  localparam int unsigned NPix = HRes * VRes;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_pop = 1'b0;
  logic [23:0] pix_data;
  logic        underflow;
  logic        cpu_req = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [23:0] cpu_wdata = '0;
  logic        cpu_gnt;
  logic        mem_en;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata = '0;

  always #5 clk = ~clk;

  vga_fb_scheduler #(
    .H_RES        (HRes),
    .V_RES        (VRes),
    .FIFO_DEPTH   (8),
    .LOW_WATER    (3),
    .UNDERFLOW_RGB(24'hFF00FF)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_frame_start(frame_start),
    .i_pix_pop    (pix_pop),
    .o_pix_data   (pix_data),
    .o_underflow  (underflow),
    .i_cpu_req    (cpu_req),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .o_cpu_gnt    (cpu_gnt),
    .o_mem_en     (mem_en),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata)
  );

  // Single-port RAM, 1-cycle read latency.
  logic [23:0] ram [512];
  initial for (int a = 0; a < 512; a++) ram[a] = 24'(a);
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[8:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[8:0]];
    end
  end

  int checks = 0;
  int failures = 0;
  int exp_rd_addr = 0;
  int frame_reads = 0;
  logic [23:0] exp_pix_q [$];
  logic [18:0] cpu_addr_q [$];
  logic [23:0] cpu_data_q [$];

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic drive_cpu();
    if (cpu_addr_q.size() > 0) begin
      cpu_req   = 1'b1;
      cpu_addr  = cpu_addr_q[0];
      cpu_wdata = cpu_data_q[0];
    end else begin
      cpu_req   = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
    end
  endtask

  // One clock cycle: drive inputs after the edge, observe the RAM bus mid-cycle, then check
  // the registered pixel just after the closing edge.
  task automatic cycle(input logic fs, input logic pop);
    logic [23:0] e;
    frame_start = fs;
    pix_pop     = pop;
    drive_cpu();
    @(negedge clk);
    if (mem_en && !mem_we) begin
      checks++;
      if (fs || exp_rd_addr >= int'(NPix) || mem_addr !== 19'(exp_rd_addr)) begin
        failures++;
        $display("FAIL scan_read: addr=%0d in_frame_start=%0b, required addr=%0d below %0d",
                 mem_addr, fs, exp_rd_addr, NPix);
      end
      exp_rd_addr++;
      frame_reads++;
    end
    if (cpu_gnt) begin
      checks++;
      if (cpu_addr_q.size() == 0) begin
        failures++;
        $display("FAIL cpu_gnt: grant with no request pending");
      end else begin
        if (!mem_en || !mem_we || mem_addr !== cpu_addr_q[0] || mem_wdata !== cpu_data_q[0]) begin
          failures++;
          $display("FAIL cpu_write: en=%0b we=%0b addr=%0d wdata=%h, required 1 1 %0d %h",
                   mem_en, mem_we, mem_addr, mem_wdata, cpu_addr_q[0], cpu_data_q[0]);
        end
        void'(cpu_addr_q.pop_front());
        void'(cpu_data_q.pop_front());
      end
    end else if (cpu_req) begin
      // A pending request may only lose its slot to a scanout read.
      checks++;
      if (fs || !(mem_en && !mem_we)) begin
        failures++;
        $display("FAIL cpu_withheld: en=%0b we=%0b fs=%0b, required a scanout read outside fs",
                 mem_en, mem_we, fs);
      end
    end
    if (fs) begin
      exp_rd_addr = 0;
      frame_reads = 0;
    end
    @(posedge clk);
    #1;
    if (pop && !fs) begin
      checks++;
      if (exp_pix_q.size() == 0) begin
        failures++;
        $display("FAIL pix_scoreboard: pix_data=%h with no expected value queued", pix_data);
      end else begin
        e = exp_pix_q.pop_front();
        if (pix_data !== e) begin
          failures++;
          $display("FAIL pix_data: got %h, required %h", pix_data, e);
        end
      end
    end
    frame_start = 1'b0;
    pix_pop     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (pix_data !== 24'd0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_pix: pix_data=%h underflow=%0b, required 0 0", pix_data, underflow);
    end
    checks++;
    if ({cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_bus: gnt=%0b en=%0b we=%0b addr=%0d wdata=%h, required all 0",
               cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(3);
    checks++;
    if (mem_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: mem_en=%0b, required 0", mem_en);
    end
  endtask

  task automatic test_prefetch();
    cycle(1'b1, 1'b0);
    idle(20);
    checks++;
    if (frame_reads != 8) begin
      failures++;
      $display("FAIL prefetch_count: reads=%0d, required 8", frame_reads);
    end
    checks++;
    if (mem_en !== 1'b0) begin
      failures++;
      $display("FAIL prefetch_stop: mem_en=%0b, required 0", mem_en);
    end
  endtask

  task automatic run_frame(input string tag);
    cycle(1'b1, 1'b0);
    idle(10);
    for (int i = 0; i < int'(NPix); i++) begin
      exp_pix_q.push_back(24'(i));
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
    end
    for (int n = 0; n < 60 && cpu_addr_q.size() > 0; n++) cycle(1'b0, 1'b0);
    idle(4);
    checks++;
    if (frame_reads != int'(NPix) || exp_rd_addr != int'(NPix)) begin
      failures++;
      $display("FAIL %s_reads: reads=%0d next=%0d, required %0d", tag, frame_reads,
               exp_rd_addr, NPix);
    end
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL %s_underflow: underflow=%0b, required 0", tag, underflow);
    end
    checks++;
    if (mem_en !== 1'b0 || cpu_addr_q.size() != 0) begin
      failures++;
      $display("FAIL %s_end: mem_en=%0b cpu_pending=%0d, required 0 0", tag, mem_en,
               cpu_addr_q.size());
    end
  endtask

  task automatic test_full_frame();
    run_frame("frame");
  endtask

  task automatic test_cpu_share();
    for (int k = 0; k < 40; k++) begin
      cpu_addr_q.push_back(19'(200 + k));
      cpu_data_q.push_back(24'hA00000 + 24'(k));
    end
    run_frame("cpu_share");
  endtask

  task automatic test_underflow();
    for (int k = 0; k < 20; k++) begin
      cpu_addr_q.push_back(19'(300 + k));
      cpu_data_q.push_back(24'hB00000 + 24'(k));
    end
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    exp_pix_q.push_back(24'hFF00FF);
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      exp_pix_q.push_back(24'(i));
      cycle(1'b0, 1'b1);
    end
    checks++;
    if (underflow !== 1'b1) begin
      failures++;
      $display("FAIL underflow_set: underflow=%0b, required 1", underflow);
    end
    cycle(1'b1, 1'b0);
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_clear: underflow=%0b, required 0", underflow);
    end
    for (int n = 0; n < 60 && cpu_addr_q.size() > 0; n++) cycle(1'b0, 1'b0);
    checks++;
    if (cpu_addr_q.size() != 0) begin
      failures++;
      $display("FAIL underflow_cpu_drain: pending=%0d, required 0", cpu_addr_q.size());
    end
  endtask

  task automatic test_frame_start_collision();
    cycle(1'b1, 1'b0);
    idle(10);
    exp_pix_q.push_back(24'd0);
    cycle(1'b0, 1'b1);
    exp_pix_q.push_back(24'd1);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if (frame_reads != 1) begin
      failures++;
      $display("FAIL collide_inflight: reads=%0d, required 1", frame_reads);
    end
    // Read return, pop and frame_start all in one cycle.
    cycle(1'b1, 1'b1);
    checks++;
    if (pix_data !== 24'd1 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL collide_hold: pix_data=%h underflow=%0b, required 000001 0",
               pix_data, underflow);
    end
    cycle(1'b0, 1'b0);
    checks++;
    if (frame_reads != 1) begin
      failures++;
      $display("FAIL collide_restart: reads=%0d, required 1 (addr 0)", frame_reads);
    end
    idle(8);
    for (int i = 0; i < 3; i++) begin
      exp_pix_q.push_back(24'(i));
      cycle(1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_midframe();
    cycle(1'b1, 1'b0);
    exp_pix_q.push_back(24'hFF00FF);
    cycle(1'b0, 1'b1);
    checks++;
    if (underflow !== 1'b1 || frame_reads != 1) begin
      failures++;
      $display("FAIL midreset_setup: underflow=%0b reads=%0d, required 1 1", underflow,
               frame_reads);
    end
    cpu_req   = 1'b1;
    cpu_addr  = 19'd5;
    cpu_wdata = 24'h123456;
    rst       = 1'b0;
    #1;
    checks++;
    if (pix_data !== 24'd0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL midreset_pix: pix_data=%h underflow=%0b, required 0 0", pix_data,
               underflow);
    end
    @(negedge clk);
    checks++;
    if ({cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL midreset_bus: gnt=%0b en=%0b we=%0b addr=%0d wdata=%h, required all 0",
               cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk);
    #1;
    rst     = 1'b1;
    cpu_req = 1'b0;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    checks++;
    if (frame_reads != 1) begin
      failures++;
      $display("FAIL midreset_restart: reads=%0d, required 1 (addr 0)", frame_reads);
    end
    idle(8);
    for (int i = 0; i < 2; i++) begin
      exp_pix_q.push_back(24'(i));
      cycle(1'b0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_prefetch();
    test_full_frame();
    test_cpu_share();
    test_underflow();
    test_frame_start_collision();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
